// File: rtl/lbp_core.sv
// lbp_core: 3x3 Local Binary Pattern compute stage.
//
// Scans a gray image held in a synchronous memory, keeps a 3x3 window of
// pixels and presents one write per pixel to the downstream write stage.
// The memory returns read data one cycle after the request.
//
// Optional build macro: LBP_BORDER_WRITE_EN
//   undefined : only interior pixels are written.
//   defined   : border pixels also get one 0x00 write each (no reads), so
//               the whole frame is written in raster order.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   gray_ready_i  image memory loaded, sampled in IDLE only
//   gray_data_i   read data, one cycle after gray_req_o
//   gray_req_o    read request
//   gray_addr_o   read address, y*IMG_W+x
//   wreq_o        one-cycle write strobe
//   wdata_o       LBP value
//   waddr_o       pixel address
//   done_o        frame complete, held until rst
//
// state  | meaning
// IDLE   | wait for gray_ready_i
// FILL   | load all 9 window pixels for the first pixel of a row
// SLIDE  | window shifted left, waiting for the new right column
// CALC   | write strobe for the current pixel
// BORDER | 0x00 write for one border pixel (border build only)
// DONE   | frame complete, held until rst
module lbp_core #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gray_ready_i,
    input  logic [7:0]    gray_data_i,
    output logic          gray_req_o,
    output logic [AW-1:0] gray_addr_o,
    output logic          wreq_o,
    output logic [7:0]    wdata_o,
    output logic [AW-1:0] waddr_o,
    output logic          done_o
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = AW - XW;
    localparam logic [XW-1:0] X_LAST_IN = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_LAST_IN = YW'(IMG_H - 2);
`ifdef LBP_BORDER_WRITE_EN
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
`endif

    typedef enum logic [2:0] {IDLE, FILL, SLIDE, CALC, BORDER, DONE} state_t;

    state_t        state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;

    // read sequencer: rcol/rrow name the window slot of the request on the bus,
    // ccol/crow the slot whose data is arriving this cycle
    logic [1:0]    rcol, rrow, col_n, row_n;
    logic [1:0]    ccol, crow;
    logic          cap_vld;
    logic          last_cap;
    logic          req_n;
    logic [AW-1:0] addr_n;

    logic [7:0]    win   [3][3];   // [column L/C/R][row T/M/B]
    logic [7:0]    win_n [3][3];
    logic [7:0]    centre, lbp;
    logic          wreq_n, done_n;
    logic [7:0]    wdata_n;
    logic [AW-1:0] waddr_n;

    assign last_cap = cap_vld && (ccol == 2'd2) && (crow == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        case (state)
            IDLE: begin
                if (gray_ready_i) begin
`ifdef LBP_BORDER_WRITE_EN
                    state_n = BORDER;
                    x_n     = '0;
                    y_n     = '0;
`else
                    state_n = FILL;
                    x_n     = XW'(1);
                    y_n     = YW'(1);
`endif
                end
            end
            FILL, SLIDE: begin
                if (last_cap) state_n = CALC;
            end
            CALC: begin
                if (x < X_LAST_IN) begin
                    state_n = SLIDE;
                    x_n     = x + XW'(1);
`ifdef LBP_BORDER_WRITE_EN
                end else begin
                    state_n = BORDER;
                    x_n     = X_MAX;
                end
`else
                end else if (y < Y_LAST_IN) begin
                    state_n = FILL;
                    x_n     = XW'(1);
                    y_n     = y + YW'(1);
                end else begin
                    state_n = DONE;
                end
`endif
            end
`ifdef LBP_BORDER_WRITE_EN
            BORDER: begin
                if (x == X_MAX) begin
                    if (y == Y_MAX) begin
                        state_n = DONE;
                    end else begin
                        x_n = '0;
                        y_n = y + YW'(1);
                    end
                end else if ((y == '0) || (y == Y_MAX)) begin
                    x_n = x + XW'(1);
                end else begin
                    state_n = FILL;
                    x_n     = XW'(1);
                end
            end
`endif
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        // window update: capture the arriving datum, shift when leaving CALC for SLIDE
        win_n = win;
        if (cap_vld) win_n[ccol][crow] = gray_data_i;
        if ((state == CALC) && (state_n == SLIDE)) begin
            win_n[0] = win_n[1];
            win_n[1] = win_n[2];
        end

        centre = win_n[1][1];
        lbp = {win_n[2][2] >= centre, win_n[1][2] >= centre, win_n[0][2] >= centre,
               win_n[2][1] >= centre, win_n[0][1] >= centre,
               win_n[2][0] >= centre, win_n[1][0] >= centre, win_n[0][0] >= centre};

        // The new right column is requested already during the CALC cycle so
        // that a pixel in the middle of a row costs 4 cycles.
        req_n  = gray_req_o;
        col_n  = rcol;
        row_n  = rrow;
        addr_n = gray_addr_o;
        if ((state_n == FILL) && (state != FILL)) begin
            req_n  = 1'b1;
            col_n  = 2'd0;
            row_n  = 2'd0;
            addr_n = {y_n - YW'(1), {XW{1'b0}}};
        end else if ((state_n == CALC) && (state != CALC) && (x < X_LAST_IN)) begin
            req_n  = 1'b1;
            col_n  = 2'd2;
            row_n  = 2'd0;
            addr_n = {y - YW'(1), x + XW'(2)};
        end else if (gray_req_o && !((rcol == 2'd2) && (rrow == 2'd2))) begin
            if (rrow == 2'd2) begin
                row_n  = 2'd0;
                col_n  = rcol + 2'd1;
                addr_n = gray_addr_o - AW'(2 * IMG_W) + AW'(1);
            end else begin
                row_n  = rrow + 2'd1;
                addr_n = gray_addr_o + AW'(IMG_W);
            end
        end else begin
            req_n = 1'b0;
        end

        wreq_n  = (state_n == CALC) || (state_n == BORDER);
        waddr_n = wreq_n ? {y_n, x_n} : waddr_o;
        wdata_n = wdata_o;
        if (state_n == CALC)   wdata_n = lbp;
        if (state_n == BORDER) wdata_n = 8'h00;
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_req_o  <= 1'b0;
            gray_addr_o <= '0;
            rcol        <= '0;
            rrow        <= '0;
            cap_vld     <= 1'b0;
            ccol        <= '0;
            crow        <= '0;
            wreq_o      <= 1'b0;
            wdata_o     <= '0;
            waddr_o     <= '0;
            done_o      <= 1'b0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    win[c][r] <= '0;
        end else begin
            gray_req_o  <= req_n;
            gray_addr_o <= addr_n;
            rcol        <= col_n;
            rrow        <= row_n;
            cap_vld     <= gray_req_o;
            ccol        <= rcol;
            crow        <= rrow;
            wreq_o      <= wreq_n;
            wdata_o     <= wdata_n;
            waddr_o     <= waddr_n;
            done_o      <= done_n;
            win         <= win_n;
        end
    end
endmodule
